// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing controller: owns the IR, walks each instruction
// through fetch/decode/execute/memory/writeback and traps on illegal encodings.
module multicycle_controller #(
  parameter int instr_width  = 32,
  parameter int alu_op_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [instr_width-1:0]  mem_rdata,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_addr_sel,
  output logic [instr_width-1:0]  ir,
  output logic                    pc_write,
  output logic                    mdr_write,
  output logic [alu_op_width-1:0] alu_op,
  output logic                    sel_bw_imm_rs2,
  output logic                    regfile_write_enable,
  output logic                    wb_sel,
  output logic                    instr_retired,
  output logic                    illegal_instr
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  state_t                  state_q, state_d;
  logic [instr_width-1:0]  ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       is_r, is_i, is_load, is_store;
  logic       legal;
  logic [3:0] alu_code;

  assign opcode   = ir_q[6:0];
  assign func3    = ir_q[14:12];
  assign func7    = ir_q[31:25];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:     legal = (func7 == F7_ZERO) ||
                        ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)));
      OP_I: begin
        case (func3)
          3'b001:  legal = (func7 == F7_ZERO);
          3'b101:  legal = (func7 == F7_ZERO) || (func7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD:  legal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE: legal = func3 inside {3'b000, 3'b001, 3'b010};
      default:  legal = 1'b0;
    endcase
  end

  // Immediate forms never subtract; func7 bit 5 only picks sra over srl there.
  always_comb begin
    alu_code = 4'd0;
    if (is_r || is_i) begin
      case (func3)
        3'b000:  alu_code = (is_r && ir_q[30]) ? 4'd1 : 4'd0;
        3'b001:  alu_code = 4'd2;
        3'b010:  alu_code = 4'd3;
        3'b011:  alu_code = 4'd4;
        3'b100:  alu_code = 4'd5;
        3'b101:  alu_code = ir_q[30] ? 4'd7 : 4'd6;
        3'b110:  alu_code = 4'd8;
        default: alu_code = 4'd9;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end
      end
      DECODE:    state_d = legal ? EXECUTE : TRAP;
      EXECUTE:   state_d = (is_load || is_store) ? MEMORY : WRITEBACK;
      MEMORY: begin
        if (mem_ready) state_d = is_load ? WRITEBACK : FETCH;
      end
      WRITEBACK: state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // The store/load completion strobes fire in the MEMORY cycle that mem_ready arrives.
  assign mem_req              = (state_q == FETCH) || (state_q == MEMORY);
  assign mem_we               = (state_q == MEMORY) && is_store;
  assign mem_addr_sel         = (state_q == MEMORY);
  assign mdr_write            = (state_q == MEMORY) && mem_ready && is_load;
  assign pc_write             = (state_q == WRITEBACK) ||
                                ((state_q == MEMORY) && mem_ready && is_store);
  assign instr_retired        = pc_write;
  assign regfile_write_enable = (state_q == WRITEBACK);
  assign illegal_instr        = (state_q == TRAP);
  assign ir                   = ir_q;
  assign alu_op               = alu_op_width'(alu_code);
  assign sel_bw_imm_rs2       = is_i || is_load || is_store;
  assign wb_sel               = is_load;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: drives instructions through a
// memory stub and checks strobes per state plus a retirement scoreboard.
module tb_multicycle_controller;

  localparam int K_ARITH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_ILL   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [31:0] ir;
  logic        pc_write, mdr_write;
  logic [3:0]  alu_op;
  logic        sel_bw_imm_rs2, regfile_write_enable, wb_sel;
  logic        instr_retired, illegal_instr;

  typedef struct {
    int   cycles;
    logic rwe;
    logic wb;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          fetch_start = 0;
  logic [31:0] last_ir = '0;

  multicycle_controller #(.instr_width(32), .alu_op_width(4)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir(ir),
    .pc_write(pc_write), .mdr_write(mdr_write), .alu_op(alu_op),
    .sel_bw_imm_rs2(sel_bw_imm_rs2), .regfile_write_enable(regfile_write_enable),
    .wb_sel(wb_sel), .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Retirement monitor: every instr_retired pulse pops the oldest expectation.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && instr_retired) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("retire_cycles", 32'(cyc_cnt - fetch_start + 1), 32'(e.cycles));
        checkOutput("retire_rwe", {31'd0, regfile_write_enable}, {31'd0, e.rwe});
        checkOutput("retire_wb_sel", {31'd0, wb_sel}, {31'd0, e.wb});
      end
    end
  end

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_pc_write"}, {31'd0, pc_write}, 32'd0);
    checkOutput({tag, "_rwe"}, {31'd0, regfile_write_enable}, 32'd0);
    checkOutput({tag, "_mdr_write"}, {31'd0, mdr_write}, 32'd0);
    checkOutput({tag, "_retired"}, {31'd0, instr_retired}, 32'd0);
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    last_ir = '0;
    checkOutput("idle_no_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("first_req_cycle2", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkQuiet("rst");
    releaseReset();
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input int kind, input int exp_alu,
                               input int exp_sel, input int fwait, input int mwait);
    int   n;
    exp_t e;
    logic ld, st;
    ld = (kind == K_LOAD);
    st = (kind == K_STORE);
    if (kind != K_ILL) begin
      e.cycles = (kind == K_LOAD) ? 5 + fwait + mwait :
                 (kind == K_STORE) ? 4 + fwait + mwait : 4 + fwait;
      e.rwe    = (kind != K_STORE);
      e.wb     = ld;
      sb.push_back(e);
    end
    n = 0;
    while (!mem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", {31'd0, mem_req}, 32'd1);
    if (!mem_req) return;
    fetch_start = cyc_cnt;
    for (int i = 0; i < fwait; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      #1;
      checkOutput("fetch_wait_addr_sel", {31'd0, mem_addr_sel}, 32'd0);
      checkOutput("fetch_wait_we", {31'd0, mem_we}, 32'd0);
      checkOutput("fetch_wait_ir", ir, last_ir);
      @(negedge clk);
      checkOutput("fetch_wait_req", {31'd0, mem_req}, 32'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = instr;
    #1;
    checkOutput("fetch_addr_sel", {31'd0, mem_addr_sel}, 32'd0);
    checkOutput("fetch_we", {31'd0, mem_we}, 32'd0);
    checkQuiet("fetch");
    @(negedge clk);
    last_ir = instr;
    // DECODE: a stray ready here must be ignored
    mem_rdata = $urandom;
    checkOutput("decode_ir", ir, instr);
    checkOutput("decode_req", {31'd0, mem_req}, 32'd0);
    checkOutput("decode_illegal", {31'd0, illegal_instr}, 32'd0);
    checkQuiet("decode");
    @(negedge clk);
    mem_ready = 1'b0;
    if (kind == K_ILL) begin
      for (int i = 0; i < 20; i++) begin
        checkOutput("trap_illegal", {31'd0, illegal_instr}, 32'd1);
        checkOutput("trap_req", {31'd0, mem_req}, 32'd0);
        checkOutput("trap_ir", ir, instr);
        checkQuiet("trap");
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      mem_ready = 1'b0;
      return;
    end
    checkOutput("exec_ir", ir, instr);
    checkOutput("exec_alu_op", {28'd0, alu_op}, 32'(exp_alu));
    checkOutput("exec_sel", {31'd0, sel_bw_imm_rs2}, 32'(exp_sel));
    checkOutput("exec_wb_sel", {31'd0, wb_sel}, {31'd0, ld});
    checkOutput("exec_req", {31'd0, mem_req}, 32'd0);
    checkQuiet("exec");
    @(negedge clk);
    if (ld || st) begin
      for (int i = 0; i < mwait; i++) begin
        checkOutput("mem_wait_req", {31'd0, mem_req}, 32'd1);
        checkOutput("mem_wait_addr_sel", {31'd0, mem_addr_sel}, 32'd1);
        checkOutput("mem_wait_we", {31'd0, mem_we}, {31'd0, st});
        checkQuiet("mem_wait");
        @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      checkOutput("mem_req", {31'd0, mem_req}, 32'd1);
      checkOutput("mem_addr_sel", {31'd0, mem_addr_sel}, 32'd1);
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, st});
      checkOutput("mem_mdr_write", {31'd0, mdr_write}, {31'd0, ld});
      checkOutput("mem_pc_write", {31'd0, pc_write}, {31'd0, st});
      checkOutput("mem_retired", {31'd0, instr_retired}, {31'd0, st});
      checkOutput("mem_rwe", {31'd0, regfile_write_enable}, 32'd0);
      @(negedge clk);
      mem_ready = 1'b0;
    end
    if (!st) begin
      checkOutput("wb_rwe", {31'd0, regfile_write_enable}, 32'd1);
      checkOutput("wb_pc_write", {31'd0, pc_write}, 32'd1);
      checkOutput("wb_retired", {31'd0, instr_retired}, 32'd1);
      checkOutput("wb_mdr_write", {31'd0, mdr_write}, 32'd0);
      checkOutput("wb_sel_val", {31'd0, wb_sel}, {31'd0, ld});
      checkOutput("wb_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    checkOutput("next_fetch_req", {31'd0, mem_req}, 32'd1);
    checkQuiet("next_fetch");
  endtask

  // Async reset in the middle of a stalled fetch
  task automatic asyncReset();
    mem_ready = 1'b0;
    checkOutput("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("async_rst_ir", ir, 32'd0);
    checkOutput("async_rst_addr_sel", {31'd0, mem_addr_sel}, 32'd0);
    checkQuiet("async_rst");
    @(negedge clk);
    releaseReset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    doReset();
    applyStimulus(32'h002081B3, K_ARITH, 0, 0, 0, 0);
    applyStimulus(32'h402081B3, K_ARITH, 1, 0, 0, 0);
    applyStimulus(32'h4020D1B3, K_ARITH, 7, 0, 1, 0);
    applyStimulus(32'h0020D1B3, K_ARITH, 6, 0, 0, 0);
    applyStimulus(32'h002091B3, K_ARITH, 2, 0, 0, 0);
    applyStimulus(32'h0020A1B3, K_ARITH, 3, 0, 0, 0);
    applyStimulus(32'h0020B1B3, K_ARITH, 4, 0, 2, 0);
    applyStimulus(32'h0020C1B3, K_ARITH, 5, 0, 0, 0);
    applyStimulus(32'h0020E1B3, K_ARITH, 8, 0, 0, 0);
    applyStimulus(32'h0020F1B3, K_ARITH, 9, 0, 0, 0);
    applyStimulus(32'h4050D093, K_ARITH, 7, 1, 0, 0);
    applyStimulus(32'h0050F093, K_ARITH, 9, 1, 0, 0);
    applyStimulus(32'h40008093, K_ARITH, 0, 1, 0, 0);
    applyStimulus(32'h00109093, K_ARITH, 2, 1, 0, 0);
    applyStimulus(32'h0000A183, K_LOAD,  0, 1, 0, 3);
    applyStimulus(32'h0000C183, K_LOAD,  0, 1, 2, 0);
    applyStimulus(32'h0020A023, K_STORE, 0, 1, 1, 2);
    applyStimulus(32'h00208023, K_STORE, 0, 1, 0, 0);
    asyncReset();
    applyStimulus(32'h002081B3, K_ARITH, 0, 0, 0, 0);
    applyStimulus(32'h0220F1B3, K_ILL, 0, 0, 0, 0);
    doReset();
    applyStimulus(32'h0000007F, K_ILL, 0, 0, 1, 0);
    doReset();
    applyStimulus(32'h0000B183, K_ILL, 0, 0, 0, 0);
    doReset();
    applyStimulus(32'h402091B3, K_ILL, 0, 0, 0, 0);
    doReset();
    applyStimulus(32'h40109093, K_ILL, 0, 0, 0, 0);
    doReset();
    applyStimulus(32'h0000B023, K_ILL, 0, 0, 0, 0);
    doReset();
    applyStimulus(32'h0000A183, K_LOAD, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
